// File: rtl/mem_arb_pkg.sv
// Shared types and line geometry for the I/D memory arbiter and its cache clients.
package mem_arb_pkg;

  localparam int unsigned AddrWidthDef   = 64;
  localparam int unsigned LineWidthDef   = 512;
  localparam int unsigned OffsetWidthDef = 6;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait
  } state_e;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-side and memory-bus-side handshake signals of the arbiter.
// The master modport is the arbiter's view; slave is the view of the caches plus memory.
interface mem_arbiter_if #(
  parameter int unsigned AddrWidth = 64,
  parameter int unsigned LineWidth = 512
);

  logic                 irequest;
  logic                 ireqack;
  logic [AddrWidth-1:0] iaddr;
  logic [LineWidth-1:0] idata;
  logic                 idone;

  logic                 drequest;
  logic                 dreqack;
  logic [AddrWidth-1:0] daddr;
  logic                 dwrite;
  logic [LineWidth-1:0] dwdata;
  logic [LineWidth-1:0] ddata;
  logic                 ddone;

  logic                 mrequest;
  logic                 mreqack;
  logic [AddrWidth-1:0] maddr;
  logic                 mwrite;
  logic [LineWidth-1:0] mwdata;
  logic [LineWidth-1:0] mrdata;
  logic                 mdone;

  modport master (
    input  irequest, iaddr,
    input  drequest, daddr, dwrite, dwdata,
    input  mreqack, mrdata, mdone,
    output ireqack, idata, idone,
    output dreqack, ddata, ddone,
    output mrequest, maddr, mwrite, mwdata
  );

  modport slave (
    output irequest, iaddr,
    output drequest, daddr, dwrite, dwdata,
    output mreqack, mrdata, mdone,
    input  ireqack, idata, idone,
    input  dreqack, ddata, ddone,
    input  mrequest, maddr, mwrite, mwdata
  );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to whoever did not own the bus last.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       ireq_i,
  input  logic       dreq_i,
  input  owner_e     last_owner_i,
  output logic [1:0] gnt_o          // bit 0 = ICache, bit 1 = DCache
);

  always_comb begin
    gnt_o = 2'b00;
    if (ireq_i && dreq_i) begin
      gnt_o = (last_owner_i == OWN_I) ? 2'b10 : 2'b01;
    end else if (ireq_i) begin
      gnt_o = 2'b01;
    end else if (dreq_i) begin
      gnt_o = 2'b10;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single memory bus between ICache and DCache with one transaction in flight.
// All outputs are registered; the round-robin pick is the only combinational decision.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AddrWidth   = AddrWidthDef,
  parameter int unsigned LineWidth   = LineWidthDef,
  parameter int unsigned OffsetWidth = OffsetWidthDef
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.master bus
);

  localparam logic [AddrWidth-1:0] LineMask =
    {{(AddrWidth - OffsetWidth){1'b1}}, {OffsetWidth{1'b0}}};

  state_e               state_q, state_d;
  owner_e               owner_q, owner_d;
  owner_e               last_q, last_d;
  logic                 ireqack_q, ireqack_d;
  logic                 dreqack_q, dreqack_d;
  logic                 idone_q, idone_d;
  logic                 ddone_q, ddone_d;
  logic                 mrequest_q, mrequest_d;
  logic [AddrWidth-1:0] maddr_q, maddr_d;
  logic                 mwrite_q, mwrite_d;
  logic [LineWidth-1:0] mwdata_q, mwdata_d;
  logic [LineWidth-1:0] idata_q, idata_d;
  logic [LineWidth-1:0] ddata_q, ddata_d;
  logic [1:0]           gnt;

  rr_arb2 u_rr_arb2 (
    .ireq_i      (bus.irequest),
    .dreq_i      (bus.drequest),
    .last_owner_i(last_q),
    .gnt_o       (gnt)
  );

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    ireqack_d  = 1'b0;
    dreqack_d  = 1'b0;
    idone_d    = 1'b0;
    ddone_d    = 1'b0;
    mrequest_d = mrequest_q;
    maddr_d    = maddr_q;
    mwrite_d   = mwrite_q;
    mwdata_d   = mwdata_q;
    idata_d    = idata_q;
    ddata_d    = ddata_q;

    unique case (state_q)
      StIdle: begin
        // Stray mreqack/mdone are ignored here simply by not looking at them.
        if (gnt[1]) begin
          owner_d    = OWN_D;
          last_d     = OWN_D;
          dreqack_d  = 1'b1;
          maddr_d    = bus.daddr & LineMask;
          mwrite_d   = bus.dwrite;
          mwdata_d   = bus.dwdata;
          mrequest_d = 1'b1;
          state_d    = StReq;
        end else if (gnt[0]) begin
          owner_d    = OWN_I;
          last_d     = OWN_I;
          ireqack_d  = 1'b1;
          maddr_d    = bus.iaddr & LineMask;
          mwrite_d   = 1'b0;
          mwdata_d   = '0;
          mrequest_d = 1'b1;
          state_d    = StReq;
        end
      end
      StReq, StWait: begin
        // mdone wins over mreqack so an ack+done in one cycle completes directly.
        if (bus.mdone) begin
          mrequest_d = 1'b0;
          state_d    = StIdle;
          if (owner_q == OWN_I) begin
            idone_d = 1'b1;
            idata_d = mwrite_q ? '0 : bus.mrdata;
          end else begin
            ddone_d = 1'b1;
            ddata_d = mwrite_q ? '0 : bus.mrdata;
          end
        end else if (state_q == StReq && bus.mreqack) begin
          mrequest_d = 1'b0;
          state_d    = StWait;
        end
      end
      default: begin
        state_d    = StIdle;
        mrequest_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      owner_q    <= OWN_I;
      last_q     <= OWN_D;
      ireqack_q  <= 1'b0;
      dreqack_q  <= 1'b0;
      idone_q    <= 1'b0;
      ddone_q    <= 1'b0;
      mrequest_q <= 1'b0;
      maddr_q    <= '0;
      mwrite_q   <= 1'b0;
      mwdata_q   <= '0;
      idata_q    <= '0;
      ddata_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      ireqack_q  <= ireqack_d;
      dreqack_q  <= dreqack_d;
      idone_q    <= idone_d;
      ddone_q    <= ddone_d;
      mrequest_q <= mrequest_d;
      maddr_q    <= maddr_d;
      mwrite_q   <= mwrite_d;
      mwdata_q   <= mwdata_d;
      idata_q    <= idata_d;
      ddata_q    <= ddata_d;
    end
  end

  assign bus.ireqack  = ireqack_q;
  assign bus.dreqack  = dreqack_q;
  assign bus.idone    = idone_q;
  assign bus.ddone    = ddone_q;
  assign bus.idata    = idata_q;
  assign bus.ddata    = ddata_q;
  assign bus.mrequest = mrequest_q;
  assign bus.maddr    = maddr_q;
  assign bus.mwrite   = mwrite_q;
  assign bus.mwdata   = mwdata_q;

  a_acks_exclusive : assert property (@(posedge clk) disable iff (reset)
    !(ireqack_q && dreqack_q));
  a_dones_exclusive : assert property (@(posedge clk) disable iff (reset)
    !(idone_q && ddone_q));
  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (reset)
    $onehot0(gnt));

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized cache/memory traffic,
// checked every cycle against a transaction-level model of the arbitration rules.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned AW = 64;
  localparam int unsigned LW = 512;
  localparam int unsigned OW = 6;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AddrWidth(AW), .LineWidth(LW)) bus ();

  mem_arbiter #(.AddrWidth(AW), .LineWidth(LW), .OffsetWidth(OW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk_b(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b want %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_a(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_v(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- reference model: one owner at a time, alternate on ties ----------------
  bit            m_busy, m_acked, m_owner, m_last, m_ever;  // owner/last: 0 = I, 1 = D
  logic          e_ireqack, e_dreqack, e_idone, e_ddone, e_mrequest, e_mwrite;
  logic [AW-1:0] e_maddr;
  logic [LW-1:0] e_mwdata, e_idata, e_ddata;

  always @(posedge clk) begin
    e_ireqack = 1'b0;
    e_dreqack = 1'b0;
    e_idone   = 1'b0;
    e_ddone   = 1'b0;
    if (reset) begin
      m_busy = 0; m_acked = 0; m_last = 1; m_ever = 0;
      e_mrequest = 1'b0; e_mwrite = 1'b0;
      e_maddr = '0; e_mwdata = '0; e_idata = '0; e_ddata = '0;
    end else if (!m_busy) begin
      if (bus.irequest || bus.drequest) begin
        if (bus.irequest && bus.drequest) m_owner = !m_last;
        else m_owner = bus.drequest;
        m_last = m_owner; m_busy = 1; m_acked = 0; m_ever = 1;
        e_mrequest = 1'b1;
        if (m_owner) begin
          e_dreqack = 1'b1;
          e_maddr   = (bus.daddr >> OW) << OW;
          e_mwrite  = bus.dwrite;
          e_mwdata  = bus.dwdata;
        end else begin
          e_ireqack = 1'b1;
          e_maddr   = (bus.iaddr >> OW) << OW;
          e_mwrite  = 1'b0;
        end
      end
    end else if (bus.mdone) begin
      m_busy = 0;
      e_mrequest = 1'b0;
      if (m_owner) begin
        e_ddone = 1'b1;
        e_ddata = e_mwrite ? '0 : bus.mrdata;
      end else begin
        e_idone = 1'b1;
        e_idata = bus.mrdata;
      end
    end else if (!m_acked && bus.mreqack) begin
      m_acked = 1;
      e_mrequest = 1'b0;
    end
    #1;
    chk_b("ireqack", bus.ireqack, e_ireqack);
    chk_b("dreqack", bus.dreqack, e_dreqack);
    chk_b("idone", bus.idone, e_idone);
    chk_b("ddone", bus.ddone, e_ddone);
    chk_b("mrequest", bus.mrequest, e_mrequest);
    chk_b("mwrite", bus.mwrite, e_mwrite);
    chk_a("maddr", bus.maddr, e_maddr);
    if (e_mwrite || !m_ever) chk_v("mwdata", bus.mwdata, e_mwdata);
    chk_v("idata", bus.idata, e_idata);
    chk_v("ddata", bus.ddata, e_ddata);
  end

  // ---------------- stimulus agents, all advanced from one process ----------------
  bit            i_out, d_out, i_auto, d_auto, stray_en, mem_busy, fix_rdata_en;
  int            i_iss_n, i_done_n, d_iss_n, d_done_n;
  int            fix_ack = -1, fix_done = -1, ackd, dond, mem_cnt;
  logic [LW-1:0] fix_rdata;
  logic [LW-1:0] pat_a = {64{8'hAA}};
  logic [LW-1:0] pat_5 = {64{8'h55}};

  task automatic issue_i(input logic [AW-1:0] a);
    bus.irequest = 1'b1; bus.iaddr = a; i_out = 1; i_iss_n++;
  endtask

  task automatic issue_d(input logic [AW-1:0] a, input logic w, input logic [LW-1:0] wd);
    bus.drequest = 1'b1; bus.daddr = a; bus.dwrite = w; bus.dwdata = wd; d_out = 1; d_iss_n++;
  endtask

  task automatic step();
    @(negedge clk);
    if (bus.ireqack) bus.irequest = 1'b0;
    if (bus.dreqack) bus.drequest = 1'b0;
    if (bus.idone) begin i_out = 0; i_done_n++; end
    if (bus.ddone) begin d_out = 0; d_done_n++; end
    if (i_auto && !i_out && $urandom_range(0, 3) == 0) issue_i({$urandom, $urandom});
    if (d_auto && !d_out && $urandom_range(0, 3) == 0)
      issue_d({$urandom, $urandom}, 1'($urandom), rand_line());
    bus.mreqack = 1'b0;
    bus.mdone   = 1'b0;
    if (!mem_busy && bus.mrequest && !reset) begin
      mem_busy = 1; mem_cnt = 0;
      ackd = (fix_ack >= 0) ? fix_ack : $urandom_range(0, 4);
      dond = (fix_done >= 0) ? fix_done : $urandom_range(0, 4);
    end
    if (mem_busy) begin
      if (mem_cnt == ackd) bus.mreqack = 1'b1;
      if (mem_cnt == ackd + dond) begin
        bus.mdone  = 1'b1;
        bus.mrdata = fix_rdata_en ? fix_rdata : rand_line();
        mem_busy   = 0;
      end
      mem_cnt++;
    end else if (stray_en && $urandom_range(0, 5) == 0) begin
      bus.mreqack = 1'($urandom);
      bus.mdone   = 1'($urandom);
      bus.mrdata  = rand_line();
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    bus.irequest = 1'b0; bus.drequest = 1'b0;
    if (i_out) i_iss_n--;
    if (d_out) d_iss_n--;
    i_out = 0; d_out = 0;
    step();
    reset = 1'b0;
  endtask

  task automatic wait_idone(input string name);
    int k = 0;
    while (!bus.idone && k < 60) begin step(); k++; end
    chk_b(name, bus.idone, 1'b1);
  endtask

  task automatic wait_ddone(input string name);
    int k = 0;
    while (!bus.ddone && k < 60) begin step(); k++; end
    chk_b(name, bus.ddone, 1'b1);
  endtask

  initial begin
    int d_before, i_base, d_base, k;
    bus.irequest = 1'b0; bus.iaddr = '0;
    bus.drequest = 1'b0; bus.daddr = '0; bus.dwrite = 1'b0; bus.dwdata = '0;
    bus.mreqack = 1'b0; bus.mdone = 1'b0; bus.mrdata = '0;
    repeat (3) step();
    reset = 1'b0;
    step();
    chk_b("rst_mrequest", bus.mrequest, 1'b0);
    chk_a("rst_maddr", bus.maddr, '0);
    chk_v("rst_idata", bus.idata, '0);

    // I-only fill
    fix_ack = 2; fix_done = 1; fix_rdata_en = 1; fix_rdata = pat_a;
    d_before = d_done_n;
    issue_i(64'h1040);
    step();
    chk_b("i_fill_ack", bus.ireqack, 1'b1);
    chk_a("i_fill_maddr", bus.maddr, 64'h1040);
    chk_a("model_maddr", e_maddr, 64'h1040);
    chk_b("i_fill_mwrite", bus.mwrite, 1'b0);
    wait_idone("i_fill_done");
    chk_v("i_fill_idata", bus.idata, pat_a);
    step();
    chk_b("i_fill_done_1cyc", bus.idone, 1'b0);
    chk_i("i_fill_no_ddone", d_done_n, d_before);

    // simultaneous after reset: I, then D, then I again
    pulse_reset();
    issue_i(64'h3000);
    issue_d(64'h4000, 1'b0, '0);
    step();
    chk_b("tie1_i_ack", bus.ireqack, 1'b1);
    chk_b("tie1_d_noack", bus.dreqack, 1'b0);
    chk_b("model_tie1_owner_i", m_owner, 1'b0);
    wait_idone("tie1_i_done");
    step();
    chk_b("tie_d_after_idone", bus.dreqack, 1'b1);
    chk_a("tie_d_maddr", bus.maddr, 64'h4000);
    wait_ddone("tie_d_done");
    chk_v("tie_d_ddata", bus.ddata, pat_a);
    issue_i(64'h3100);
    issue_d(64'h4100, 1'b0, '0);
    step();
    chk_b("tie2_i_ack", bus.ireqack, 1'b1);
    chk_b("tie2_d_noack", bus.dreqack, 1'b0);
    wait_idone("tie2_i_done");
    wait_ddone("tie2_d_done");

    // D writeback with line alignment
    fix_ack = 3; fix_done = 2;
    issue_d(64'h2007F, 1'b1, pat_5);
    step();
    chk_b("wb_ack", bus.dreqack, 1'b1);
    chk_a("wb_maddr", bus.maddr, 64'h20040);
    chk_b("wb_mwrite", bus.mwrite, 1'b1);
    chk_v("wb_mwdata", bus.mwdata, pat_5);
    k = 0;
    while (bus.mrequest && k < 10) begin
      step(); k++;
      if (bus.mrequest) begin
        chk_a("wb_maddr_hold", bus.maddr, 64'h20040);
        chk_v("wb_mwdata_hold", bus.mwdata, pat_5);
      end
    end
    wait_ddone("wb_done");
    chk_v("wb_ddata_zero", bus.ddata, '0);

    // mreqack and mdone in the same cycle, then immediate next grant
    fix_ack = 0; fix_done = 0;
    issue_i(64'h5000);
    step();
    chk_b("same_ack", bus.ireqack, 1'b1);
    step();
    chk_b("same_idone", bus.idone, 1'b1);
    chk_b("same_mreq_low", bus.mrequest, 1'b0);
    issue_d(64'h6000, 1'b0, '0);
    step();
    chk_b("same_single_pulse", bus.idone, 1'b0);
    chk_b("turnaround_dack", bus.dreqack, 1'b1);
    wait_ddone("turnaround_ddone");

    // slow mreqack while D waits behind I
    fix_ack = 5; fix_done = 2; fix_rdata = rand_line();
    issue_i(64'h8000);
    step();
    chk_b("slow_ack", bus.ireqack, 1'b1);
    issue_d(64'h9040, 1'b0, '0);
    for (int j = 0; j < 5; j++) begin
      step();
      chk_b("slow_mreq_held", bus.mrequest, 1'b1);
      chk_a("slow_maddr_held", bus.maddr, 64'h8000);
      chk_b("slow_d_blocked", bus.dreqack, 1'b0);
    end
    wait_idone("slow_idone");
    chk_v("slow_idata", bus.idata, fix_rdata);
    step();
    chk_b("slow_d_after", bus.dreqack, 1'b1);
    wait_ddone("slow_ddone");

    // reset while waiting for mdone; the late mdone must vanish
    fix_ack = 0; fix_done = 6;
    issue_i(64'h9000);
    step();
    chk_b("rw_ack", bus.ireqack, 1'b1);
    step();
    step();
    chk_b("rw_in_wait", bus.mrequest, 1'b0);
    pulse_reset();
    chk_a("rw_maddr0", bus.maddr, '0);
    chk_v("rw_idata0", bus.idata, '0);
    chk_v("rw_ddata0", bus.ddata, '0);
    k = 0;
    while (mem_busy && k < 20) begin
      step(); k++;
      chk_b("rw_no_idone", bus.idone, 1'b0);
      chk_b("rw_no_ddone", bus.ddone, 1'b0);
    end
    fix_done = 1;
    issue_i(64'hA0C5);
    step();
    chk_b("rw_regrant", bus.ireqack, 1'b1);
    chk_a("rw_regrant_maddr", bus.maddr, 64'hA0C0);
    wait_idone("rw_regrant_done");

    // random traffic with stray bus pulses while idle
    fix_ack = -1; fix_done = -1; fix_rdata_en = 0; stray_en = 1;
    i_base = i_iss_n - i_done_n;
    d_base = d_iss_n - d_done_n;
    i_auto = 1; d_auto = 1;
    repeat (2000) step();
    i_auto = 0; d_auto = 0; stray_en = 0;
    k = 0;
    while ((i_out || d_out) && k < 200) begin step(); k++; end
    chk_i("drain_i", i_iss_n - i_done_n, i_base);
    chk_i("drain_d", d_iss_n - d_done_n, d_base);
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
